// File: rtl/txn_wd_pkg.sv
// Shared types and helpers for the transaction watchdog.
package txn_wd_pkg;

  // Upper bounds that size the shared slot record; instances use narrower fields.
  localparam int MAX_SLOTS = 16;
  localparam int MAX_ID_W  = 16;
  localparam int MAX_CNT_W = 16;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    LIVE    = 2'd1,
    EXPIRED = 2'd2
  } slot_state_e;

  typedef struct packed {
    slot_state_e              state;
    logic [MAX_ID_W-1:0]      id;
    logic [MAX_CNT_W-1:0]     cnt;
  } slot_t;

  // Isolates the lowest set bit of a request vector (one-hot result, zero if none set).
  function automatic logic [MAX_SLOTS-1:0] lowest_set(input logic [MAX_SLOTS-1:0] vec);
    return vec & (~vec + MAX_SLOTS'(1));
  endfunction

endpackage

// File: rtl/txn_wd_if.sv
// Issue / completion / timeout-report signal bundle for the watchdog.
interface txn_wd_if #(
  parameter int ID_W      = 4,
  parameter int NUM_SLOTS = 4
);
  localparam int LIVE_W = $clog2(NUM_SLOTS + 1);

  logic              issue_valid;
  logic [ID_W-1:0]   issue_id;
  logic              issue_ready;
  logic              cmpl_valid;
  logic [ID_W-1:0]   cmpl_id;
  logic              abort_all;
  logic              to_valid;
  logic [ID_W-1:0]   to_id;
  logic              to_ready;
  logic [LIVE_W-1:0] live_cnt;
  logic              cmpl_unexp;

  modport master (
    output issue_valid, issue_id, cmpl_valid, cmpl_id, abort_all, to_ready,
    input  issue_ready, to_valid, to_id, live_cnt, cmpl_unexp
  );

  modport slave (
    input  issue_valid, issue_id, cmpl_valid, cmpl_id, abort_all, to_ready,
    output issue_ready, to_valid, to_id, live_cnt, cmpl_unexp
  );

endinterface

// File: rtl/txn_wd_slot.sv
// One watchdog slot: FREE -> LIVE (counting down) -> EXPIRED -> FREE.
module txn_wd_slot
  import txn_wd_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc,
  input  logic [ID_W-1:0] alloc_id,
  input  logic            cmpl_hit,
  input  logic            abort,
  input  logic            rpt_done,
  output slot_state_e     state,
  output logic [ID_W-1:0] id
);

  slot_t slot_q;
  slot_t slot_d;

  // Next slot contents; a completion or abort beats expiry at the final count.
  always_comb begin
    slot_d = slot_q;
    case (slot_q.state)
      FREE: begin
        if (alloc) begin
          slot_d.state = LIVE;
          slot_d.id    = MAX_ID_W'(alloc_id);
          slot_d.cnt   = MAX_CNT_W'(TIMEOUT);
        end
      end
      LIVE: begin
        if (cmpl_hit || abort) begin
          slot_d.state = FREE;
        end else if (slot_q.cnt == MAX_CNT_W'(1)) begin
          slot_d.state = EXPIRED;
        end else begin
          slot_d.cnt = slot_q.cnt - MAX_CNT_W'(1);
        end
      end
      EXPIRED: begin
        if (rpt_done) begin
          slot_d.state = FREE;
        end
      end
      default: slot_d.state = FREE;
    endcase
  end

  // Slot register; reset empties the slot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '{state: FREE, id: '0, cnt: '0};
    end else begin
      slot_q <= slot_d;
    end
  end

  assign state = slot_q.state;
  assign id    = slot_q.id[ID_W-1:0];

endmodule

// File: rtl/txn_watchdog.sv
// Transaction timeout tracker: slot array plus allocation, match and report priority.
module txn_watchdog
  import txn_wd_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int ID_W      = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  txn_wd_if.slave  bus
);

  localparam int LIVE_W = $clog2(NUM_SLOTS + 1);

  slot_state_e          slot_state [NUM_SLOTS];
  logic [ID_W-1:0]      slot_id    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] free_vec;
  logic [NUM_SLOTS-1:0] live_vec;
  logic [NUM_SLOTS-1:0] exp_vec;
  logic [NUM_SLOTS-1:0] match_vec;
  logic [NUM_SLOTS-1:0] alloc_oh;
  logic [NUM_SLOTS-1:0] hit_oh;
  logic [NUM_SLOTS-1:0] cur_oh;
  logic [NUM_SLOTS-1:0] rpt_oh;
  logic [NUM_SLOTS-1:0] rpt_done_oh;
  logic                 unexp_d;
  logic                 unexp_q;
  logic [ID_W-1:0]      to_id;
  logic [LIVE_W-1:0]    live_cnt;

  function automatic logic [NUM_SLOTS-1:0] pick_lowest(input logic [NUM_SLOTS-1:0] vec);
    return NUM_SLOTS'(lowest_set(MAX_SLOTS'(vec)));
  endfunction

  // Classify every slot and find LIVE slots whose ID matches the completion.
  always_comb begin
    free_vec  = '0;
    live_vec  = '0;
    exp_vec   = '0;
    match_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_vec[i]  = (slot_state[i] == FREE);
      live_vec[i]  = (slot_state[i] == LIVE);
      exp_vec[i]   = (slot_state[i] == EXPIRED);
      match_vec[i] = (slot_state[i] == LIVE) && (slot_id[i] == bus.cmpl_id);
    end
  end

  // A held report keeps to_id stable; otherwise the lowest EXPIRED slot is offered.
  assign alloc_oh    = bus.issue_valid ? pick_lowest(free_vec) : '0;
  assign hit_oh      = bus.cmpl_valid ? pick_lowest(match_vec) : '0;
  assign cur_oh      = (rpt_oh != '0) ? rpt_oh : pick_lowest(exp_vec);
  assign rpt_done_oh = bus.to_ready ? cur_oh : '0;
  assign unexp_d     = bus.cmpl_valid && (match_vec == '0) && !bus.abort_all;

  // Report-slot holding register and the registered unexpected-completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_oh  <= '0;
      unexp_q <= 1'b0;
    end else begin
      rpt_oh  <= bus.to_ready ? '0 : cur_oh;
      unexp_q <= unexp_d;
    end
  end

  // Report ID mux and count of LIVE slots.
  always_comb begin
    to_id    = '0;
    live_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cur_oh[i]) begin
        to_id = to_id | slot_id[i];
      end
      live_cnt = live_cnt + LIVE_W'(live_vec[i]);
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    txn_wd_slot #(
      .ID_W    (ID_W),
      .TIMEOUT (TIMEOUT)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .alloc    (alloc_oh[g]),
      .alloc_id (bus.issue_id),
      .cmpl_hit (hit_oh[g]),
      .abort    (bus.abort_all),
      .rpt_done (rpt_done_oh[g]),
      .state    (slot_state[g]),
      .id       (slot_id[g])
    );
  end

  assign bus.issue_ready = |free_vec;
  assign bus.to_valid    = |cur_oh;
  assign bus.to_id       = to_id;
  assign bus.live_cnt    = live_cnt;
  assign bus.cmpl_unexp  = unexp_q;

endmodule

// File: tb/tb_txn_watchdog.sv
// Self-checking bench for txn_watchdog: directed scenarios plus random traffic
// compared against a deadline-based reference model.
module tb_txn_watchdog;

  localparam int NUM_SLOTS = 4;
  localparam int ID_W      = 4;
  localparam int TIMEOUT   = 8;

  localparam int M_FREE    = 0;
  localparam int M_WAITING = 1;
  localparam int M_TIMED   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  txn_wd_if #(.ID_W(ID_W), .NUM_SLOTS(NUM_SLOTS)) bus ();

  txn_watchdog #(
    .NUM_SLOTS (NUM_SLOTS),
    .ID_W      (ID_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each entry remembers its ID and the absolute edge at which it times out.
  int m_state    [NUM_SLOTS];
  int m_id       [NUM_SLOTS];
  int m_deadline [NUM_SLOTS];
  int m_held;
  int m_unexp;
  int edge_no;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic int mLowest(input int kind);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (m_state[i] == kind) return i;
    end
    return -1;
  endfunction

  function automatic int mReport();
    return (m_held >= 0) ? m_held : mLowest(M_TIMED);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      m_state[i]    = M_FREE;
      m_id[i]       = 0;
      m_deadline[i] = 0;
    end
    m_held  = -1;
    m_unexp = 0;
  endtask

  task automatic modelStep(input int iv, input int iid, input int cv, input int cid,
                           input int ab, input int tr);
    int alloc;
    int hit;
    int cur;
    int nstate [NUM_SLOTS];
    alloc = -1;
    hit   = -1;
    cur   = mReport();
    if (iv != 0) alloc = mLowest(M_FREE);
    if (cv != 0) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit < 0 && m_state[i] == M_WAITING && m_id[i] == cid) hit = i;
      end
    end
    m_unexp = (cv != 0 && hit < 0 && ab == 0) ? 1 : 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      nstate[i] = m_state[i];
      if (m_state[i] == M_WAITING) begin
        if (i == hit || ab != 0) nstate[i] = M_FREE;
        else if (m_deadline[i] == edge_no) nstate[i] = M_TIMED;
      end else if (m_state[i] == M_TIMED && i == cur && tr != 0) begin
        nstate[i] = M_FREE;
      end
    end
    m_held = (cur >= 0 && tr == 0) ? cur : -1;
    for (int i = 0; i < NUM_SLOTS; i++) m_state[i] = nstate[i];
    if (alloc >= 0) begin
      m_state[alloc]    = M_WAITING;
      m_id[alloc]       = iid;
      m_deadline[alloc] = edge_no + TIMEOUT;
    end
  endtask

  task automatic checkAll();
    int cur;
    int n_free;
    int n_live;
    cur    = mReport();
    n_free = 0;
    n_live = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (m_state[i] == M_FREE)    n_free++;
      if (m_state[i] == M_WAITING) n_live++;
    end
    checkOutput("issue_ready", int'(bus.issue_ready), (n_free > 0) ? 1 : 0);
    checkOutput("to_valid",    int'(bus.to_valid),    (cur >= 0) ? 1 : 0);
    if (cur >= 0) checkOutput("to_id", int'(bus.to_id), m_id[cur]);
    checkOutput("live_cnt",    int'(bus.live_cnt),    n_live);
    checkOutput("cmpl_unexp",  int'(bus.cmpl_unexp),  m_unexp);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic applyStimulus(input int iv, input int iid, input int cv, input int cid,
                               input int ab, input int tr);
    bus.issue_valid = (iv != 0);
    bus.issue_id    = ID_W'(iid);
    bus.cmpl_valid  = (cv != 0);
    bus.cmpl_id     = ID_W'(cid);
    bus.abort_all   = (ab != 0);
    bus.to_ready    = (tr != 0);
    modelStep(iv, iid, cv, cid, ab, tr);
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n, input int tr);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, tr);
  endtask

  task automatic clearInputs();
    bus.issue_valid = 1'b0;
    bus.issue_id    = '0;
    bus.cmpl_valid  = 1'b0;
    bus.cmpl_id     = '0;
    bus.abort_all   = 1'b0;
    bus.to_ready    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int order [4];
    order   = '{1, 8, 3, 4};
    edge_no = 0;
    clearInputs();
    modelReset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAll();
    checkOutput("rst_to_id", int'(bus.to_id), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkAll();

    $display("[TB] completion at the last honoured edge");
    applyStimulus(1, 3, 0, 0, 0, 0);
    idle(7, 0);
    applyStimulus(0, 0, 1, 3, 0, 0);
    checkOutput("s1_live_cnt", int'(bus.live_cnt), 0);
    checkOutput("s1_to_valid", int'(bus.to_valid), 0);
    checkOutput("s1_unexp",    int'(bus.cmpl_unexp), 0);
    idle(4, 0);

    $display("[TB] expiry report held under backpressure");
    applyStimulus(1, 5, 0, 0, 0, 0);
    idle(7, 0);
    checkOutput("s2_not_yet", int'(bus.to_valid), 0);
    idle(1, 0);
    checkOutput("s2_to_valid", int'(bus.to_valid), 1);
    checkOutput("s2_to_id",    int'(bus.to_id), 5);
    idle(3, 0);
    checkOutput("s2_id_stable", int'(bus.to_id), 5);
    idle(1, 1);
    checkOutput("s2_drained", int'(bus.to_valid), 0);
    checkOutput("s2_ready",   int'(bus.issue_ready), 1);

    $display("[TB] full, ignored issue, slot reuse order");
    for (int k = 1; k <= 4; k++) applyStimulus(1, k, 0, 0, 0, 0);
    checkOutput("s3_full_ready", int'(bus.issue_ready), 0);
    checkOutput("s3_full_live",  int'(bus.live_cnt), 4);
    applyStimulus(1, 6, 0, 0, 0, 0);
    checkOutput("s3_ignored", int'(bus.live_cnt), 4);
    applyStimulus(0, 0, 1, 2, 0, 0);
    checkOutput("s3_ready_again", int'(bus.issue_ready), 1);
    applyStimulus(1, 8, 0, 0, 0, 0);
    idle(9, 0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("s3_report_order", int'(bus.to_id), order[k]);
      idle(1, 1);
    end
    checkOutput("s3_empty", int'(bus.to_valid), 0);

    $display("[TB] duplicate IDs and unexpected completion");
    applyStimulus(1, 7, 0, 0, 0, 0);
    applyStimulus(1, 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 7, 0, 0);
    checkOutput("s4_live", int'(bus.live_cnt), 1);
    applyStimulus(0, 0, 1, 9, 0, 0);
    checkOutput("s4_unexp", int'(bus.cmpl_unexp), 1);
    idle(1, 0);
    checkOutput("s4_unexp_pulse", int'(bus.cmpl_unexp), 0);
    idle(5, 0);
    checkOutput("s4_second_expired", int'(bus.to_id), 7);
    idle(1, 1);

    $display("[TB] abort with expired slot, simultaneous issue and completion");
    applyStimulus(1, 1, 0, 0, 0, 0);
    idle(1, 0);
    applyStimulus(1, 2, 0, 0, 0, 0);
    idle(6, 0);
    checkOutput("s5_expired", int'(bus.to_id), 1);
    applyStimulus(1, 10, 1, 13, 1, 0);
    checkOutput("s5_live_after_abort", int'(bus.live_cnt), 1);
    checkOutput("s5_no_unexp",         int'(bus.cmpl_unexp), 0);
    checkOutput("s5_report_kept",      int'(bus.to_id), 1);
    idle(1, 1);
    checkOutput("s5_drained", int'(bus.to_valid), 0);
    applyStimulus(0, 0, 1, 10, 0, 0);
    checkOutput("s5_live_zero", int'(bus.live_cnt), 0);
    idle(4, 0);

    $display("[TB] reset during a pending report");
    applyStimulus(1, 11, 0, 0, 0, 0);
    idle(5, 0);
    for (int k = 12; k <= 14; k++) applyStimulus(1, k, 0, 0, 0, 0);
    checkOutput("s6_pre_valid", int'(bus.to_valid), 1);
    checkOutput("s6_pre_live",  int'(bus.live_cnt), 3);
    clearInputs();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("s6_rst_ready", int'(bus.issue_ready), 1);
    checkOutput("s6_rst_valid", int'(bus.to_valid), 0);
    checkOutput("s6_rst_id",    int'(bus.to_id), 0);
    checkOutput("s6_rst_live",  int'(bus.live_cnt), 0);
    checkOutput("s6_rst_unexp", int'(bus.cmpl_unexp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 15, 0, 0, 0, 0);
    checkOutput("s6_after_live", int'(bus.live_cnt), 1);
    applyStimulus(0, 0, 1, 15, 0, 0);

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      applyStimulus(int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) < 3) ? 1 : 0,
                    int'($urandom_range(0, 7)),
                    ($urandom_range(0, 49) == 0) ? 1 : 0,
                    ($urandom_range(0, 2) != 0) ? 1 : 0);
    end
    idle(20, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
